template_grabber: RTL

- Parameterised template-capture block for the face tracker.
- Samples a TW x TH window, optionally decimated by STEP, out of the raster-ordered grayscale camera stream into a flat register array read by the correlator.
- Replaces the fixed 32x32 every-other-clock capture with frame-aligned, coordinate-exact capture.
- Adds an arm/done handshake, one-shot and continuous modes, and incomplete-frame detection.

---
 rtl/template_grabber.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/template_grabber.sv
// Purpose: captures a TW x TH window (decimated by STEP) from a raster pixel stream into a flat register array.
// Latency: pixel on input -> visible on template_flat 2 cycles later; done/incomplete/busy are registered.
// Backpressure: none; the camera stream cannot be stalled, so every pixel strobe is consumed on arrival.
module template_grabber #(
  parameter int TW      = 32,
  parameter int TH      = 32,
  parameter int PIX_W   = 4,
  parameter int STEP    = 1,
  parameter int COORD_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arm,
  input  logic                      continuous,
  input  logic [COORD_W-1:0]        win_left,
  input  logic [COORD_W-1:0]        win_top,
  input  logic                      sof,
  input  logic                      pix_valid,
  input  logic [COORD_W-1:0]        pix_x,
  input  logic [COORD_W-1:0]        pix_y,
  input  logic [PIX_W-1:0]          pix_data,
  output logic [TW*TH*PIX_W-1:0]    template_flat,
  output logic                      template_rdy,
  output logic                      busy,
  output logic                      done,
  output logic                      incomplete
);

  localparam int NSLOT = TW * TH;
  localparam int IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int CNT_W = $clog2(NSLOT + 1);
  localparam int SH    = $clog2(STEP);
  // Offsets are one bit wider than coordinates so a pixel left/above the
  // window wraps to a large value and fails the span test.
  localparam int DW    = COORD_W + 1;

  localparam logic [DW-1:0]    SPAN_X = DW'(TW * STEP);
  localparam logic [DW-1:0]    SPAN_Y = DW'(TH * STEP);
  localparam logic [DW-1:0]    ALIGN  = DW'(STEP - 1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(NSLOT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    CAPTURING = 2'd2,
    READY     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [COORD_W-1:0] wl_q, wl_d;
  logic [COORD_W-1:0] wt_q, wt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               inc_q, inc_d;

  // Write pipeline stage between hit detection and the array.
  logic               wr_q;
  logic [IDX_W-1:0]   slot_q, slot_d;
  logic [PIX_W-1:0]   dat_q;

  logic [NSLOT-1:0][PIX_W-1:0] tpl_q;

  logic [DW-1:0] dx, dy;
  logic          hit;
  logic          start;
  logic          complete;

  // Window-relative offsets, hit test and destination slot for the current pixel.
  always_comb begin
    dx     = {1'b0, pix_x} - {1'b0, wl_q};
    dy     = {1'b0, pix_y} - {1'b0, wt_q};
    hit    = pix_valid && !sof && (state_q == CAPTURING) &&
             (dx < SPAN_X) && (dy < SPAN_Y) &&
             ((dx & ALIGN) == '0) && ((dy & ALIGN) == '0);
    slot_d = IDX_W'(dy >> SH) * IDX_W'(TW) + IDX_W'(dx >> SH);
  end

  // The sample landing this cycle finishes the capture when it is the last one counted.
  assign complete = wr_q && (state_q == CAPTURING) && (cnt_q == LAST);

  // Next-state and pulse decode; completion outranks a coincident sof.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done_d  = 1'b0;
    inc_d   = 1'b0;
    rdy_d   = rdy_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          rdy_d   = 1'b0;
        end
      end
      ARMED: begin
        if (sof) begin
          state_d = CAPTURING;
          start   = 1'b1;
        end
      end
      CAPTURING: begin
        if (complete) begin
          state_d = READY;
          done_d  = 1'b1;
          rdy_d   = 1'b1;
        end else if (sof) begin
          // Frame ended short: flag it and restart on the new frame.
          inc_d = 1'b1;
          start = 1'b1;
        end
      end
      READY: begin
        if (arm) begin
          state_d = ARMED;
          rdy_d   = 1'b0;
        end else if (continuous && sof) begin
          // Continuous re-capture overwrites in place; rdy stays high.
          state_d = CAPTURING;
          start   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window latch, sample counter and registered busy decode.
  always_comb begin
    wl_d   = start ? win_left : wl_q;
    wt_d   = start ? win_top  : wt_q;
    cnt_d  = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (wr_q && (state_q == CAPTURING)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    busy_d = (state_d == ARMED) || (state_d == CAPTURING);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control registers: window, count and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wl_q   <= '0;
      wt_q   <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      wl_q   <= wl_d;
      wt_q   <= wt_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
      done_q <= done_d;
      inc_q  <= inc_d;
    end
  end

  // Hit pipeline stage: remember slot and data for next cycle's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      slot_q <= '0;
      dat_q  <= '0;
    end else begin
      wr_q   <= hit;
      slot_q <= slot_d;
      dat_q  <= pix_data;
    end
  end

  // Template array write; a write pending across a restart still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tpl_q <= '0;
    end else if (wr_q) begin
      tpl_q[slot_q] <= dat_q;
    end
  end

  assign template_flat = tpl_q;
  assign template_rdy  = rdy_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign incomplete    = inc_q;

endmodule
